// File: rtl/spine_pkg.sv
// Shared types and constants for the spine-side leaf adapter.
// The top module's optional statistics counters are enabled by the
// SPINE_STATS_EN macro; nothing in this package depends on it.
package spine_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int ADDR_W_DEF = 6;

  // The destination always occupies the top six bits of a flit.
  localparam int DEST_W   = 6;
  localparam int DEST_MSB = DWIDTH_DEF - 1;
  localparam int DEST_LSB = DWIDTH_DEF - DEST_W;

  // Widest flit the dest helper can take apart.
  localparam int MAX_FLIT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } egress_state_t;

  // Pull the destination field out of a flit of width dwidth.
  // The flit must be zero-extended to MAX_FLIT_W.
  function automatic logic [DEST_W-1:0] flit_dest(
    input logic [MAX_FLIT_W-1:0] flit,
    input int                    dwidth
  );
    return flit[dwidth-1 -: DEST_W];
  endfunction

endpackage

// File: rtl/spine_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// The head entry is on o_rdata whenever o_empty is low, and it holds steady
// until it is popped. A push into a full FIFO only lands when it is paired
// with a pop. A pop from an empty FIFO is ignored.
module spine_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Write the incoming flit into the slot at the write pointer.
  // NOTE: the storage array has no reset because r_level alone decides which
  // entries are valid, and a reset on the array would prevent RAM inference.
  // NOTE: sequential state always uses non-blocking assignment, so every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Advance the pointers and track the occupancy. DEPTH is a power of two,
  // so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spine_leaf_adapter.sv
// Spine-side endpoint for one leaf-router spine link.
//
// Ingress: the leaf's spine output has no backpressure, so each flit goes
// into a FWFT FIFO that drains to the spine core over valid/ready. A flit
// that arrives while the FIFO is full and not being popped is dropped and
// counted.
//
// Egress: core flits become single-cycle valid pulses toward the leaf,
// with MIN_GAP forced idle cycles after each pulse.
//
// Define SPINE_STATS_EN to add the 16-bit tx/rx flit counters. Without it,
// tx_flit_cnt and rx_flit_cnt are tied to zero.
module spine_leaf_adapter
  import spine_pkg::*;
#(
  parameter  int DWIDTH  = DWIDTH_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int DEPTH   = 8,
  parameter  int MIN_GAP = 0,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // Ingress from the leaf router
  input  logic [DWIDTH-1:0] leaf_out_data,
  input  logic              leaf_out_valid,
  // Ingress to the spine core
  output logic [DWIDTH-1:0] core_tx_data,
  output logic [ADDR_W-1:0] core_tx_dest,
  output logic              core_tx_valid,
  input  logic              core_tx_ready,
  // Egress from the spine core
  input  logic [DWIDTH-1:0] core_rx_data,
  input  logic [ADDR_W-1:0] core_rx_dest,
  input  logic              core_rx_valid,
  output logic              core_rx_ready,
  // Egress to the leaf router
  output logic [DWIDTH-1:0] leaf_in_data,
  output logic              leaf_in_valid,
  output logic [ADDR_W-1:0] leaf_dest_addr,
  // Status
  output logic [LVL_W-1:0]  fifo_level,
  output logic [7:0]        drop_cnt,
  output logic              overflow,
  output logic [15:0]       tx_flit_cnt,
  output logic [15:0]       rx_flit_cnt
);

  localparam int GAP_W = 4;

  // ---------------------------------------------------------------- ingress
  logic [DWIDTH-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [7:0]        r_drop_cnt;
  logic              r_overflow;

  assign w_pop  = core_tx_valid && core_tx_ready;
  assign w_push = leaf_out_valid && (!w_full || w_pop);
  assign w_drop = leaf_out_valid && w_full && !w_pop;

  spine_sync_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (DEPTH)
  ) u_ingress_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_push),
    .i_wdata (leaf_out_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign core_tx_valid = !w_empty;
  assign core_tx_data  = w_head;
  assign core_tx_dest  = ADDR_W'(flit_dest(MAX_FLIT_W'(w_head), DWIDTH));

  // Count flits lost to overflow (saturating) and latch the sticky flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      r_overflow <= 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;

  // ----------------------------------------------------------------- egress
  egress_state_t     r_state;
  egress_state_t     w_state_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic              r_live;
  logic              w_rx_ready;
  logic              w_capture;
  logic [DWIDTH-1:0] r_leaf_data;
  logic [ADDR_W-1:0] r_leaf_dest;

  // Hold core_rx_ready low until the first clock edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Egress state and gap counter registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Next-state logic and core-side ready. With MIN_GAP=0, SEND keeps
  // accepting so that flits go out back to back.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_rx_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_rx_ready = r_live;
        if (r_live && core_rx_valid) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (MIN_GAP == 0) begin
          w_rx_ready  = 1'b1;
          w_state_nxt = core_rx_valid ? SEND : IDLE;
        end else begin
          w_state_nxt = GAP;
          w_gap_nxt   = GAP_W'(MIN_GAP - 1);
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_capture = w_rx_ready && core_rx_valid;

  // Capture the accepted core flit. It is held for the leaf until the next
  // capture.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_leaf_data <= '0;
      r_leaf_dest <= '0;
    end else if (w_capture) begin
      r_leaf_data <= core_rx_data;
      r_leaf_dest <= core_rx_dest;
    end
  end

  assign core_rx_ready  = w_rx_ready;
  assign leaf_in_valid  = (r_state == SEND);
  assign leaf_in_data   = r_leaf_data;
  assign leaf_dest_addr = r_leaf_dest;

  // ------------------------------------------------------------- statistics
`ifdef SPINE_STATS_EN
  logic [15:0] r_tx_cnt;
  logic [15:0] r_rx_cnt;

  // Count core pops and leaf pulses. Both counters wrap at 16 bits.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      if (leaf_in_valid) begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
    end
  end

  assign tx_flit_cnt = r_tx_cnt;
  assign rx_flit_cnt = r_rx_cnt;
`else
  assign tx_flit_cnt = '0;
  assign rx_flit_cnt = '0;
`endif

endmodule

// File: tb/tb_spine_leaf_adapter.sv
// Self-checking bench for spine_leaf_adapter.
// u_dut uses MIN_GAP=0 and u_gap2 uses MIN_GAP=2. Both instances share every input.
// A queue/arithmetic model is checked against the outputs on every falling
// edge. Directed literal checks pin the model down.
module tb_spine_leaf_adapter;

  localparam int DEPTH = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [15:0] leaf_out_data = '0;
  logic        leaf_out_valid = 1'b0;
  logic        core_tx_ready = 1'b0;
  logic [15:0] core_rx_data = '0;
  logic [5:0]  core_rx_dest = '0;
  logic        core_rx_valid = 1'b0;

  logic [15:0] tx_data, li_data, g2_tx_data, g2_li_data;
  logic [5:0]  tx_dest, li_dest, g2_tx_dest, g2_li_dest;
  logic        tx_valid, rx_ready, li_valid, ovf;
  logic        g2_tx_valid, g2_rx_ready, g2_li_valid, g2_ovf;
  logic [3:0]  level, g2_level;
  logic [7:0]  drop, g2_drop;
  logic [15:0] txc, rxc, g2_txc, g2_rxc;

  spine_leaf_adapter #(.DWIDTH(16), .ADDR_W(6), .DEPTH(DEPTH), .MIN_GAP(0)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .core_tx_data(tx_data), .core_tx_dest(tx_dest), .core_tx_valid(tx_valid),
    .core_tx_ready(core_tx_ready),
    .core_rx_data(core_rx_data), .core_rx_dest(core_rx_dest),
    .core_rx_valid(core_rx_valid), .core_rx_ready(rx_ready),
    .leaf_in_data(li_data), .leaf_in_valid(li_valid), .leaf_dest_addr(li_dest),
    .fifo_level(level), .drop_cnt(drop), .overflow(ovf),
    .tx_flit_cnt(txc), .rx_flit_cnt(rxc)
  );

  spine_leaf_adapter #(.DWIDTH(16), .ADDR_W(6), .DEPTH(DEPTH), .MIN_GAP(2)) u_gap2 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .core_tx_data(g2_tx_data), .core_tx_dest(g2_tx_dest), .core_tx_valid(g2_tx_valid),
    .core_tx_ready(core_tx_ready),
    .core_rx_data(core_rx_data), .core_rx_dest(core_rx_dest),
    .core_rx_valid(core_rx_valid), .core_rx_ready(g2_rx_ready),
    .leaf_in_data(g2_li_data), .leaf_in_valid(g2_li_valid), .leaf_dest_addr(g2_li_dest),
    .fifo_level(g2_level), .drop_cnt(g2_drop), .overflow(g2_ovf),
    .tx_flit_cnt(g2_txc), .rx_flit_cnt(g2_rxc)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    bit          live;      // first edge after reset seen
    int          cyc;       // edges since reset release
    int          earliest;  // first edge index at which a new flit may be taken
    bit          pulse;     // leaf_in_valid expected this cycle
    logic [15:0] data;
    logic [5:0]  dest;
    int          rxc;
  } eg_t;

  logic [15:0] m_q[$];
  int          m_drop = 0;
  bit          m_ovf = 0;
  int          m_txc = 0;
  eg_t         m_e0 = '{0, 0, 0, 0, 16'h0, 6'h0, 0};
  eg_t         m_e2 = '{0, 0, 0, 0, 16'h0, 6'h0, 0};

  function automatic bit eg_ready(input eg_t e);
    return e.live && (e.cyc >= e.earliest);
  endfunction

  // One clock edge of the egress rules. A flit accepted at edge c pulses in the
  // next cycle. The next acceptance may happen at edge c+1 when there is no gap,
  // or at edge c+gap+2 otherwise (pulse cycle, gap cycles, then one idle cycle).
  function automatic eg_t eg_step(input eg_t e, input int gap);
    eg_t n = e;
    if (e.pulse) n.rxc = (e.rxc + 1) % 65536;
    if (eg_ready(e) && core_rx_valid) begin
      n.pulse    = 1;
      n.data     = core_rx_data;
      n.dest     = core_rx_dest;
      n.earliest = e.cyc + ((gap == 0) ? 1 : gap + 2);
    end else begin
      n.pulse = 0;
    end
    n.cyc  = e.cyc + 1;
    n.live = 1;
    return n;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_q.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_txc  = 0;
      m_e0   = '{0, 0, 0, 0, 16'h0, 6'h0, 0};
      m_e2   = '{0, 0, 0, 0, 16'h0, 6'h0, 0};
    end else begin
      bit was_full, do_pop;
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() > 0) && core_tx_ready;
      if (do_pop) begin
        void'(m_q.pop_front());
        m_txc = (m_txc + 1) % 65536;
      end
      if (leaf_out_valid) begin
        if (!was_full || do_pop) m_q.push_back(leaf_out_data);
        else begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1;
        end
      end
      m_e0 = eg_step(m_e0, 0);
      m_e2 = eg_step(m_e2, 2);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge ACLK) begin
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("tx_data", 32'(tx_data), 32'(m_q[0]));
      check("tx_dest", 32'(tx_dest), 32'(m_q[0] >> 10));
    end
    check("fifo_level", 32'(level), 32'(m_q.size()));
    check("drop_cnt", 32'(drop), 32'(m_drop));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("rx_ready", 32'(rx_ready), 32'(eg_ready(m_e0)));
    check("leaf_valid", 32'(li_valid), 32'(m_e0.pulse));
    check("leaf_data", 32'(li_data), 32'(m_e0.data));
    check("leaf_dest", 32'(li_dest), 32'(m_e0.dest));
    check("g2_rx_ready", 32'(g2_rx_ready), 32'(eg_ready(m_e2)));
    check("g2_leaf_valid", 32'(g2_li_valid), 32'(m_e2.pulse));
    check("g2_leaf_data", 32'(g2_li_data), 32'(m_e2.data));
    check("g2_leaf_dest", 32'(g2_li_dest), 32'(m_e2.dest));
`ifdef SPINE_STATS_EN
    check("tx_flit_cnt", 32'(txc), 32'(m_txc));
    check("rx_flit_cnt", 32'(rxc), 32'(m_e0.rxc));
    check("g2_rx_flit_cnt", 32'(g2_rxc), 32'(m_e2.rxc));
`else
    check("tx_flit_cnt", 32'(txc), 32'h0);
    check("rx_flit_cnt", 32'(rxc), 32'h0);
`endif
  end

  task automatic step();
    @(negedge ACLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [4:0] ev;
    logic [4:0] er;
    ev = 5'b10001;
    er = 5'b01000;

    #1 ARESETn = 1'b0;
    step();
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_level", 32'(level), 32'h0);
    step();
    ARESETn = 1'b1;
    step();
    check("post_reset_rx_ready", 32'(rx_ready), 32'h1);

    // Single flit: valid one cycle after the push, then popped.
    leaf_out_valid = 1'b1;
    leaf_out_data  = 16'hA5C3;
    step();
    leaf_out_valid = 1'b0;
    check("single_valid", 32'(tx_valid), 32'h1);
    check("single_dest", 32'(tx_dest), 32'h29);
    check("single_data", 32'(tx_data), 32'hA5C3);
    check("single_level", 32'(level), 32'h1);
    core_tx_ready = 1'b1;
    step();
    check("single_popped", 32'(tx_valid), 32'h0);
    check("single_level0", 32'(level), 32'h0);
    core_tx_ready = 1'b0;

    // Overflow: push 10 flits with no pops.
    for (int i = 1; i <= 10; i++) begin
      leaf_out_valid = 1'b1;
      leaf_out_data  = 16'h1000 + 16'(i);
      step();
    end
    leaf_out_valid = 1'b0;
    check("ovf_level", 32'(level), 32'h8);
    check("ovf_drop", 32'(drop), 32'h2);
    check("ovf_flag", 32'(ovf), 32'h1);
    check("ovf_head", 32'(tx_data), 32'h1001);

    // Push and pop together while full: the flit is kept and nothing is dropped.
    leaf_out_valid = 1'b1;
    leaf_out_data  = 16'h100B;
    core_tx_ready  = 1'b1;
    step();
    leaf_out_valid = 1'b0;
    core_tx_ready  = 1'b0;
    check("full_pp_level", 32'(level), 32'h8);
    check("full_pp_drop", 32'(drop), 32'h2);
    check("full_pp_head", 32'(tx_data), 32'h1002);

    // Drain everything in order.
    core_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] exp_head;
      exp_head = (k < 7) ? (16'h1002 + 16'(k)) : 16'h100B;
      check("drain_head", 32'(tx_data), 32'(exp_head));
      step();
    end
    core_tx_ready = 1'b0;
    check("drain_level", 32'(level), 32'h0);
    check("drain_valid", 32'(tx_valid), 32'h0);
`ifdef SPINE_STATS_EN
    check("tx_cnt_10", 32'(txc), 32'd10);
`endif
    repeat (3) step();

    // MIN_GAP=0: three back-to-back pulses.
    core_rx_valid = 1'b1;
    core_rx_data  = 16'hD000;
    core_rx_dest  = 6'h01;
    step();
    check("b2b_v0", 32'(li_valid), 32'h1);
    check("b2b_d0", 32'(li_data), 32'hD000);
    check("b2b_a0", 32'(li_dest), 32'h01);
    check("b2b_rdy", 32'(rx_ready), 32'h1);
    core_rx_data = 16'hD001;
    core_rx_dest = 6'h02;
    step();
    check("b2b_v1", 32'(li_valid), 32'h1);
    check("b2b_d1", 32'(li_data), 32'hD001);
    check("b2b_a1", 32'(li_dest), 32'h02);
    core_rx_data = 16'hD002;
    core_rx_dest = 6'h03;
    step();
    check("b2b_v2", 32'(li_valid), 32'h1);
    check("b2b_d2", 32'(li_data), 32'hD002);
    check("b2b_a2", 32'(li_dest), 32'h03);
    core_rx_valid = 1'b0;
    step();
    check("b2b_end", 32'(li_valid), 32'h0);
    check("b2b_hold_data", 32'(li_data), 32'hD002);
    check("b2b_hold_dest", 32'(li_dest), 32'h03);
    repeat (5) step();

    // MIN_GAP=2: the core holds valid across two flits.
    core_rx_valid = 1'b1;
    core_rx_data  = 16'hE000;
    core_rx_dest  = 6'h11;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gap2_valid", 32'(g2_li_valid), 32'(ev[i]));
      check("gap2_ready", 32'(g2_rx_ready), 32'(er[i]));
      if (i == 0) begin
        check("gap2_d0", 32'(g2_li_data), 32'hE000);
        core_rx_data = 16'hE001;
        core_rx_dest = 6'h12;
      end
      if (i == 4) begin
        check("gap2_d1", 32'(g2_li_data), 32'hE001);
        check("gap2_a1", 32'(g2_li_dest), 32'h12);
      end
    end
    core_rx_valid = 1'b0;
    repeat (5) step();

    // Asynchronous reset with 4 flits buffered and egress in flight.
    for (int i = 1; i <= 4; i++) begin
      leaf_out_valid = 1'b1;
      leaf_out_data  = 16'h2000 + 16'(i);
      step();
    end
    leaf_out_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'h4);
    core_rx_valid = 1'b1;
    core_rx_data  = 16'h7777;
    core_rx_dest  = 6'h3F;
    step();
    check("pre_rst_pulse", 32'(li_valid), 32'h1);
    #2 ARESETn = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_leaf_valid", 32'(li_valid), 32'h0);
    check("rst_leaf_data", 32'(li_data), 32'h0);
    check("rst_leaf_dest", 32'(li_dest), 32'h0);
    check("rst_g2_valid", 32'(g2_li_valid), 32'h0);
    check("rst_txc", 32'(txc), 32'h0);
    check("rst_rxc", 32'(rxc), 32'h0);
    core_rx_valid = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
    repeat (5) step();
    check("post_rst_valid", 32'(tx_valid), 32'h0);
    check("post_rst_level", 32'(level), 32'h0);
    check("post_rst_leaf", 32'(li_valid), 32'h0);
    check("post_rst_leaf_data", 32'(li_data), 32'h0);
    check("post_rst_ready", 32'(rx_ready), 32'h1);
    check("post_rst_txc", 32'(txc), 32'h0);
    check("post_rst_rxc", 32'(rxc), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
